forward_hazard_unit: RTL and testbench

FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

---
 rtl/forward_hazard_unit.sv | 133 +++++++++++++
 tb/tb_forward_hazard_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit: dual-lane EX/MEM/WB tag pipeline producing operand forwarding selects,
// load-use stall, N-flag select, architectural N flag and a saturating stall counter.
module forward_hazard_unit #(
    parameter int AW      = 3,
    parameter bit R0_ZERO = 1'b1,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    id_valid,
    input  logic [AW-1:0] id_rs0_a,
    input  logic [AW-1:0] id_rs0_b,
    input  logic [AW-1:0] id_rs1_a,
    input  logic [AW-1:0] id_rs1_b,
    input  logic [AW-1:0] id_rd0,
    input  logic [AW-1:0] id_rd1,
    input  logic [1:0]    id_we,
    input  logic [1:0]    id_ld,
    input  logic [1:0]    id_setn,
    input  logic          hold,
    input  logic          flush,
    input  logic [1:0]    mem_n,
    input  logic [1:0]    wb_n,
    output logic [2:0]    fwd0_a,
    output logic [2:0]    fwd0_b,
    output logic [2:0]    fwd1_a,
    output logic [2:0]    fwd1_b,
    output logic          stall,
    output logic [1:0]    n_sel,
    output logic          n_arch,
    output logic [CW-1:0] stall_cnt
);
    typedef struct packed {
        logic          v;
        logic          we;
        logic          ld;
        logic          setn;
        logic [AW-1:0] rd;
    } tag_t;

    tag_t [1:0] id_tag, ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [1:0][AW-1:0] id_rsa, id_rsb, rsa_q, rsa_d, rsb_q, rsb_d;
    logic n_arch_q, n_arch_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic unused_bits;

    // mem_n is muxed downstream under n_sel; WB load bits are never consulted
    assign unused_bits = ^{mem_n, wb_q[0].ld, wb_q[1].ld};

    assign id_tag[0] = {id_valid[0], id_we[0], id_ld[0], id_setn[0], id_rd0};
    assign id_tag[1] = {id_valid[1], id_we[1], id_ld[1], id_setn[1], id_rd1};
    assign id_rsa    = {id_rs1_a, id_rs0_a};
    assign id_rsb    = {id_rs1_b, id_rs0_b};

    function automatic logic hit(input tag_t t, input logic [AW-1:0] rs);
        return t.v && t.we && (t.rd == rs) && !(R0_ZERO && (t.rd == '0));
    endfunction

    // loads in MEM have no data yet, so they are skipped in favour of WB
    function automatic logic [2:0] fsel(input logic [AW-1:0] rs);
        return (hit(mem_q[1], rs) && !mem_q[1].ld) ? 3'b010 :
               (hit(mem_q[0], rs) && !mem_q[0].ld) ? 3'b001 :
               hit(wb_q[1], rs)                    ? 3'b100 :
               hit(wb_q[0], rs)                    ? 3'b011 : 3'b000;
    endfunction

    assign fwd0_a    = fsel(rsa_q[0]);
    assign fwd0_b    = fsel(rsb_q[0]);
    assign fwd1_a    = fsel(rsa_q[1]);
    assign fwd1_b    = fsel(rsb_q[1]);
    assign n_sel     = (mem_q[1].v && mem_q[1].setn) ? 2'b10 :
                       (mem_q[0].v && mem_q[0].setn) ? 2'b01 : 2'b00;
    assign n_arch    = n_arch_q;
    assign stall_cnt = cnt_q;

    always_comb begin
        stall = 1'b0;
        for (int l = 0; l < 2; l++)
            for (int k = 0; k < 2; k++)
                if (id_valid[l] && ex_q[k].ld && (hit(ex_q[k], id_rsa[l]) || hit(ex_q[k], id_rsb[l])))
                    stall = 1'b1;
        if (flush)
            stall = 1'b0;
    end

    always_comb begin
        ex_d     = ex_q;
        mem_d    = mem_q;
        wb_d     = wb_q;
        rsa_d    = rsa_q;
        rsb_d    = rsb_q;
        n_arch_d = n_arch_q;
        cnt_d    = cnt_q;
        if (!hold) begin
            mem_d = ex_q;
            wb_d  = mem_q;
            if (flush || stall) begin
                ex_d = '0;
            end else begin
                ex_d  = id_tag;
                rsa_d = id_rsa;
                rsb_d = id_rsb;
            end
            n_arch_d = (wb_q[1].v && wb_q[1].setn) ? wb_n[1] :
                       (wb_q[0].v && wb_q[0].setn) ? wb_n[0] : n_arch_q;
            if (stall && (cnt_q != '1))
                cnt_d = cnt_q + CW'(1);
        end else if (flush) begin
            ex_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            n_arch_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            ex_q     <= ex_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
            n_arch_q <= n_arch_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        rsa_q <= rsa_d;
        rsb_q <= rsb_d;
    end
endmodule

// File: tb/tb_forward_hazard_unit.sv
// tb_forward_hazard_unit: directed scenario tests for forward_hazard_unit (default build plus
// an R0_ZERO=0, CW=2 build sharing the same inputs).
module tb_forward_hazard_unit;
    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] id_valid, id_we, id_ld, id_setn, mem_n, wb_n;
    logic [2:0] id_rs0_a, id_rs0_b, id_rs1_a, id_rs1_b, id_rd0, id_rd1;
    logic hold, flush;
    logic [2:0] fwd0_a, fwd0_b, fwd1_a, fwd1_b;
    logic stall, n_arch;
    logic [1:0] n_sel;
    logic [15:0] stall_cnt;
    logic [2:0] fwd0_a2, fwd0_b2, fwd1_a2, fwd1_b2;
    logic stall2, n_arch2;
    logic [1:0] n_sel2;
    logic [1:0] stall_cnt2;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    forward_hazard_unit dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs0_a(id_rs0_a), .id_rs0_b(id_rs0_b), .id_rs1_a(id_rs1_a), .id_rs1_b(id_rs1_b),
        .id_rd0(id_rd0), .id_rd1(id_rd1), .id_we(id_we), .id_ld(id_ld), .id_setn(id_setn),
        .hold(hold), .flush(flush), .mem_n(mem_n), .wb_n(wb_n),
        .fwd0_a(fwd0_a), .fwd0_b(fwd0_b), .fwd1_a(fwd1_a), .fwd1_b(fwd1_b),
        .stall(stall), .n_sel(n_sel), .n_arch(n_arch), .stall_cnt(stall_cnt)
    );

    forward_hazard_unit #(.AW(3), .R0_ZERO(1'b0), .CW(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs0_a(id_rs0_a), .id_rs0_b(id_rs0_b), .id_rs1_a(id_rs1_a), .id_rs1_b(id_rs1_b),
        .id_rd0(id_rd0), .id_rd1(id_rd1), .id_we(id_we), .id_ld(id_ld), .id_setn(id_setn),
        .hold(hold), .flush(flush), .mem_n(mem_n), .wb_n(wb_n),
        .fwd0_a(fwd0_a2), .fwd0_b(fwd0_b2), .fwd1_a(fwd1_a2), .fwd1_b(fwd1_b2),
        .stall(stall2), .n_sel(n_sel2), .n_arch(n_arch2), .stall_cnt(stall_cnt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        id_valid = '0; id_we = '0; id_ld = '0; id_setn = '0;
        id_rs0_a = '0; id_rs0_b = '0; id_rs1_a = '0; id_rs1_b = '0;
        id_rd0 = '0; id_rd1 = '0;
    endtask

    task automatic lane(input bit l, input logic w, input logic ld, input logic sn,
                        input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
        id_valid[l] = 1'b1; id_we[l] = w; id_ld[l] = ld; id_setn[l] = sn;
        if (l == 1'b0) begin
            id_rd0 = rd; id_rs0_a = ra; id_rs0_b = rb;
        end else begin
            id_rd1 = rd; id_rs1_a = ra; id_rs1_b = rb;
        end
    endtask

    task automatic do_reset();
        idle();
        hold = 1'b0; flush = 1'b0; mem_n = '0; wb_n = '0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0; hold = 1'b1; flush = 1'b1; mem_n = '0; wb_n = '0;
        step();
        step();
        rst_n = 1'b1; hold = 1'b0; flush = 1'b0;
        settle();
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
        checks++; if (n_arch !== 1'b0) begin errors++; $display("FAIL reset_narch: got %b want 0", n_arch); end
        checks++; if (n_sel !== 2'b00) begin errors++; $display("FAIL reset_nsel: got %b want 00", n_sel); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if ({fwd0_a, fwd0_b, fwd1_a, fwd1_b} !== 12'd0) begin errors++; $display("FAIL reset_fwd: got %h want 000", {fwd0_a, fwd0_b, fwd1_a, fwd1_b}); end
    endtask

    task automatic test_fwd_ex_mem_wb();
        do_reset();
        lane(0, 1, 0, 0, 3'd3, 3'd0, 3'd0);
        step();
        idle(); lane(1, 1, 0, 0, 3'd1, 3'd3, 3'd0);
        step();
        idle(); lane(1, 0, 0, 0, 3'd0, 3'd3, 3'd0);
        settle();
        checks++; if (fwd1_a !== 3'b001) begin errors++; $display("FAIL fwd_exmem: got %b want 001", fwd1_a); end
        checks++; if (fwd1_b !== 3'b000) begin errors++; $display("FAIL fwd_nomatch: got %b want 000", fwd1_b); end
        step();
        settle();
        checks++; if (fwd1_a !== 3'b011) begin errors++; $display("FAIL fwd_memwb: got %b want 011", fwd1_a); end
    endtask

    task automatic test_two_writers();
        do_reset();
        lane(0, 1, 0, 0, 3'd5, 3'd0, 3'd0);
        lane(1, 1, 0, 0, 3'd5, 3'd0, 3'd0);
        step();
        idle(); lane(0, 0, 0, 0, 3'd0, 3'd5, 3'd5);
        step();
        settle();
        checks++; if (fwd0_a !== 3'b010) begin errors++; $display("FAIL two_wr_mem: got %b want 010", fwd0_a); end
        step();
        settle();
        checks++; if (fwd0_b !== 3'b100) begin errors++; $display("FAIL two_wr_wb: got %b want 100", fwd0_b); end
    endtask

    task automatic test_priority();
        do_reset();
        lane(1, 1, 0, 0, 3'd4, 3'd0, 3'd0);
        step();
        idle(); lane(0, 1, 0, 0, 3'd4, 3'd0, 3'd0);
        step();
        idle(); lane(1, 0, 0, 0, 3'd0, 3'd0, 3'd4);
        step();
        settle();
        checks++; if (fwd1_b !== 3'b001) begin errors++; $display("FAIL prio_mem_over_wb: got %b want 001", fwd1_b); end
    endtask

    task automatic test_load_use();
        do_reset();
        lane(0, 1, 1, 0, 3'd2, 3'd0, 3'd0);
        step();
        idle(); lane(1, 0, 0, 0, 3'd0, 3'd2, 3'd0);
        settle();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", stall); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL lu_cnt0: got %0d want 0", stall_cnt); end
        step();
        settle();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release: got %b want 0", stall); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt1: got %0d want 1", stall_cnt); end
        step();
        settle();
        checks++; if (fwd1_a !== 3'b011) begin errors++; $display("FAIL lu_fwd: got %b want 011", fwd1_a); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt_after: got %0d want 1", stall_cnt); end
    endtask

    task automatic test_mem_load_skip();
        do_reset();
        lane(0, 1, 0, 0, 3'd2, 3'd0, 3'd0);
        step();
        idle(); lane(1, 1, 1, 0, 3'd2, 3'd0, 3'd0);
        step();
        idle(); id_rs0_a = 3'd2;
        settle();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL invalid_lane_stall: got %b want 0", stall); end
        step();
        settle();
        checks++; if (fwd0_a !== 3'b011) begin errors++; $display("FAIL mem_load_skip: got %b want 011", fwd0_a); end
    endtask

    task automatic test_r0();
        do_reset();
        lane(0, 1, 0, 0, 3'd0, 3'd0, 3'd0);
        step();
        idle(); lane(0, 0, 0, 0, 3'd1, 3'd0, 3'd0);
        step();
        settle();
        checks++; if (fwd0_a !== 3'b000) begin errors++; $display("FAIL r0_fwd: got %b want 000", fwd0_a); end
        checks++; if (fwd0_a2 !== 3'b001) begin errors++; $display("FAIL r0_fwd_nozero: got %b want 001", fwd0_a2); end
        do_reset();
        lane(0, 1, 1, 0, 3'd0, 3'd0, 3'd0);
        step();
        idle(); lane(0, 0, 0, 0, 3'd1, 3'd0, 3'd0);
        settle();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_stall: got %b want 0", stall); end
        checks++; if (stall2 !== 1'b1) begin errors++; $display("FAIL r0_stall_nozero: got %b want 1", stall2); end
    endtask

    task automatic test_flush_hold();
        do_reset();
        lane(0, 1, 1, 0, 3'd7, 3'd0, 3'd0);
        step();
        idle(); lane(0, 0, 0, 0, 3'd0, 3'd7, 3'd0); lane(1, 1, 0, 1, 3'd4, 3'd0, 3'd0);
        flush = 1'b1;
        settle();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", stall); end
        step();
        flush = 1'b0; idle();
        settle();
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL flush_cnt: got %0d want 0", stall_cnt); end
        step();
        settle();
        checks++; if (n_sel !== 2'b00) begin errors++; $display("FAIL flush_bubble: got %b want 00", n_sel); end
        do_reset();
        lane(0, 1, 0, 1, 3'd6, 3'd0, 3'd0);
        step();
        idle(); lane(0, 0, 0, 0, 3'd0, 3'd6, 3'd0); lane(1, 1, 1, 0, 3'd7, 3'd0, 3'd0);
        step();
        idle(); lane(0, 0, 0, 0, 3'd0, 3'd7, 3'd0);
        hold = 1'b1; wb_n = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step();
            settle();
            checks++; if ({fwd0_a, n_sel, stall, n_arch} !== {3'b001, 2'b01, 1'b1, 1'b0}) begin
                errors++; $display("FAIL hold_outputs cyc%0d: got fwd=%b nsel=%b stall=%b narch=%b want 001 01 1 0", i, fwd0_a, n_sel, stall, n_arch);
            end
            checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL hold_cnt cyc%0d: got %0d want 0", i, stall_cnt); end
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        settle();
        checks++; if (n_sel !== 2'b01) begin errors++; $display("FAIL hold_flush_mem: got %b want 01", n_sel); end
        hold = 1'b0;
        settle();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hold_flush_bubble: got %b want 0", stall); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL hold_flush_cnt: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_nflag();
        do_reset();
        lane(1, 1, 0, 1, 3'd3, 3'd0, 3'd0);
        lane(0, 1, 0, 1, 3'd1, 3'd0, 3'd0);
        step();
        idle();
        step();
        mem_n = 2'b10;
        settle();
        checks++; if (n_sel !== 2'b10) begin errors++; $display("FAIL nsel_lane1: got %b want 10", n_sel); end
        step();
        wb_n = 2'b10;
        settle();
        checks++; if (n_arch !== 1'b0) begin errors++; $display("FAIL narch_early: got %b want 0", n_arch); end
        step();
        settle();
        checks++; if (n_arch !== 1'b1) begin errors++; $display("FAIL narch_wb1: got %b want 1", n_arch); end
        wb_n = 2'b00;
        lane(0, 1, 0, 1, 3'd3, 3'd0, 3'd0);
        step();
        idle(); lane(0, 0, 0, 0, 3'd0, 3'd3, 3'd0);
        step();
        settle();
        checks++; if (fwd0_a !== 3'b001) begin errors++; $display("FAIL pre_rst_fwd: got %b want 001", fwd0_a); end
        checks++; if (n_arch !== 1'b1) begin errors++; $display("FAIL narch_hold: got %b want 1", n_arch); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        settle();
        checks++; if ({n_arch, fwd0_a, n_sel} !== 6'd0) begin errors++; $display("FAIL mid_rst: got narch=%b fwd=%b nsel=%b want 0 000 00", n_arch, fwd0_a, n_sel); end
    endtask

    task automatic test_saturate();
        do_reset();
        lane(0, 1, 1, 0, 3'd2, 3'd2, 3'd0);
        for (int i = 0; i < 8; i++) step();
        settle();
        checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL cnt_count: got %0d want 4", stall_cnt); end
        checks++; if (stall_cnt2 !== 2'd3) begin errors++; $display("FAIL cnt_saturate: got %0d want 3", stall_cnt2); end
    endtask

    initial begin
        test_reset();
        test_fwd_ex_mem_wb();
        test_two_writers();
        test_priority();
        test_load_use();
        test_mem_load_skip();
        test_r0();
        test_flush_hold();
        test_nflag();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
